// File: rtl/usb_uart_tx_if.sv
// usb_uart_tx_if: valid/get byte pipeline between the USB OUT endpoint
// receive buffer (master) and the serial transmitter (slave).
`timescale 1ns/1ps

interface usb_uart_tx_if;
    logic [7:0] uart_out_data;
    logic       uart_out_valid;
    logic       uart_out_get;

    modport master (
        output uart_out_data,
        output uart_out_valid,
        input  uart_out_get
    );

    modport slave (
        input  uart_out_data,
        input  uart_out_valid,
        output uart_out_get
    );
endinterface

// File: rtl/usb_uart_tx.sv
// usb_uart_tx: pulls bytes from the endpoint pipeline and sends them as
// LSB-first 8N1 frames (STOP_BITS stop bits) on a registered TX line.
// Define USB_UART_TX_PARITY_EN to insert one even-parity bit after data bit 7.
`timescale 1ns/1ps

module usb_uart_tx #(
    parameter int CLKS_PER_BIT = 417,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          reset,
    usb_uart_tx_if.slave  up,
    output logic          uart_tx,
    output logic          tx_busy
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

`ifdef USB_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_next;
    logic [2:0]       bit_idx;
    logic [2:0]       idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             stop_cnt;
    logic             stop_next;
    logic             tx_next;
    logic             get;
    logic             fetch;
    logic             bit_end;
`ifdef USB_UART_TX_PARITY_EN
    logic             parity;
    logic             parity_next;
`endif

    assign bit_end         = (baud_cnt == '0);
    assign up.uart_out_get = get;
    assign tx_busy         = (state != IDLE);

    // Next-state, counter and next-line-level logic; a fetch reloads a new byte from IDLE or the last stop cycle
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        idx_next   = bit_idx;
        shift_next = shift;
        stop_next  = stop_cnt;
        tx_next    = uart_tx;
        get        = 1'b0;
        fetch      = 1'b0;
`ifdef USB_UART_TX_PARITY_EN
        parity_next = parity;
`endif
        case (state)
            IDLE: begin
                if (up.uart_out_valid) begin
                    fetch = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_next  = CNT_MAX;
                    idx_next   = 3'd0;
                    state_next = DATA;
                    tx_next    = shift[0];
                end else begin
                    baud_next = baud_cnt - CNT_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next  = CNT_MAX;
                    shift_next = {1'b0, shift[7:1]};
                    idx_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef USB_UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity;
`else
                        state_next = STOP;
                        stop_next  = 1'b0;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        tx_next = shift[1];
                    end
                end else begin
                    baud_next = baud_cnt - CNT_ONE;
                end
            end
`ifdef USB_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    baud_next  = CNT_MAX;
                    state_next = STOP;
                    stop_next  = 1'b0;
                    tx_next    = 1'b1;
                end else begin
                    baud_next = baud_cnt - CNT_ONE;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt == STOP_LAST) begin
                        if (up.uart_out_valid) begin
                            fetch = 1'b1;
                        end else begin
                            state_next = IDLE;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        stop_next = stop_cnt + 1'b1;
                        baud_next = CNT_MAX;
                    end
                end else begin
                    baud_next = baud_cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        if (fetch) begin
            get        = reset;
            shift_next = up.uart_out_data;
            baud_next  = CNT_MAX;
            state_next = START;
            tx_next    = 1'b0;
`ifdef USB_UART_TX_PARITY_EN
            parity_next = ^up.uart_out_data;
`endif
        end
    end

    // State, counters, shift register and the registered TX line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            stop_cnt <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= idx_next;
            shift    <= shift_next;
            stop_cnt <= stop_next;
            uart_tx  <= tx_next;
        end
    end

`ifdef USB_UART_TX_PARITY_EN
    // Parity of the latched byte, captured at fetch since the shifter consumes the data bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity <= 1'b0;
        end else begin
            parity <= parity_next;
        end
    end
`endif

endmodule

// File: tb/tb_usb_uart_tx.sv
// tb_usb_uart_tx: drives two transmitters (1 and 2 stop bits, CLKS_PER_BIT=4)
// and compares line, get and busy every cycle against a frame-level model.
`timescale 1ns/1ps

module tb_usb_uart_tx;

    localparam int CPB = 4;
`ifdef USB_UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic tx1;
    logic busy1;
    logic tx2;
    logic busy2;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] q[$];

    usb_uart_tx_if up1();
    usb_uart_tx_if up2();

    usb_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .up      (up1),
        .uart_tx (tx1),
        .tx_busy (busy1)
    );

    usb_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk     (clk),
        .reset   (reset),
        .up      (up2),
        .uart_tx (tx2),
        .tx_busy (busy2)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Line level for one bit slot of a frame: start, 8 data bits LSB first, optional parity, stop bits
    function automatic logic frame_bit(logic [7:0] b, int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (P == 1 && slot == 9) return ($countones(b) % 2) == 1;
        return 1'b1;
    endfunction

    function automatic logic obs_tx(int sel);
        return (sel == 1) ? tx1 : tx2;
    endfunction

    function automatic logic obs_busy(int sel);
        return (sel == 1) ? busy1 : busy2;
    endfunction

    function automatic logic obs_get(int sel);
        return (sel == 1) ? up1.uart_out_get : up2.uart_out_get;
    endfunction

    task automatic set_in(int sel, logic v, logic [7:0] d);
        if (sel == 1) begin
            up1.uart_out_valid = v;
            up1.uart_out_data  = d;
            up2.uart_out_valid = 1'b0;
        end else begin
            up2.uart_out_valid = v;
            up2.uart_out_data  = d;
            up1.uart_out_valid = 1'b0;
        end
    endtask

    task automatic check_output(string tag, logic obs, logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_all(int sel, string where, logic g, logic t, logic b);
        check_output($sformatf("get dut%0d %s", sel, where), obs_get(sel), g);
        check_output($sformatf("tx dut%0d %s", sel, where), obs_tx(sel), t);
        check_output($sformatf("busy dut%0d %s", sel, where), obs_busy(sel), b);
    endtask

    // Streams every byte in q back to back; valid and data wander freely except at the cycles a get is due
    task automatic apply_stimulus(int sel, int cut);
        int n     = q.size();
        int stops = (sel == 1) ? 1 : 2;
        int len   = (9 + P + stops) * CPB;
        int last  = n * len + 1;
        if (cut >= 0 && cut < last) last = cut;
        for (int c = 0; c <= last; c++) begin
            logic       v;
            logic [7:0] d;
            logic       g_exp;
            logic       t_exp;
            logic       b_exp;
            g_exp = (c % len == 0) && (c / len < n);
            v     = g_exp ? 1'b1 : (c >= n * len) ? 1'b0 : 1'($urandom);
            d     = g_exp ? q[c / len] : 8'($urandom);
            if (c == 0 || c > n * len) t_exp = 1'b1;
            else t_exp = frame_bit(q[(c - 1) / len], ((c - 1) % len) / CPB);
            b_exp = (c >= 1) && (c <= n * len);
            @(posedge clk);
            #1;
            set_in(sel, v, d);
            @(negedge clk);
            check_all(sel, $sformatf("cyc%0d", c), g_exp, t_exp, b_exp);
        end
    endtask

    // Abandons a frame part-way by asserting reset between clock edges
    task automatic reset_midframe(logic [7:0] b, int cut);
        q = '{b};
        apply_stimulus(1, cut);
        #2;
        reset = 1'b0;
        set_in(1, 1'b1, b);
        #1;
        check_all(1, "async reset", 1'b0, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_all(1, "held reset", 1'b0, 1'b1, 1'b0);
        end
        set_in(1, 1'b0, b);
        #2;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_all(1, "after reset", 1'b0, 1'b1, 1'b0);
        end
    endtask

    // Bounds total run time in case the bench itself gets stuck
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    // Directed and randomized sequence
    initial begin
        reset = 1'b0;
        up1.uart_out_valid = 1'b1;
        up1.uart_out_data  = 8'hFF;
        up2.uart_out_valid = 1'b1;
        up2.uart_out_data  = 8'hFF;
        repeat (4) begin
            @(negedge clk);
            check_all(1, "in reset", 1'b0, 1'b1, 1'b0);
            check_all(2, "in reset", 1'b0, 1'b1, 1'b0);
        end
        up1.uart_out_valid = 1'b0;
        up2.uart_out_valid = 1'b0;
        #2;
        reset = 1'b1;

        q = '{8'h55};
        apply_stimulus(1, -1);
        q = '{8'hA5, 8'h3C};
        apply_stimulus(1, -1);
        q = '{8'h00};
        apply_stimulus(2, -1);
        q = '{8'h07};
        apply_stimulus(1, -1);
        q = '{8'h07, 8'hC3};
        apply_stimulus(2, -1);

        repeat (10) begin
            int n;
            int sel;
            n   = int'($urandom_range(1, 3));
            sel = int'($urandom_range(1, 2));
            q.delete();
            repeat (n) q.push_back(8'($urandom));
            apply_stimulus(sel, -1);
        end

        reset_midframe(8'h0F, 18);
        reset_midframe(8'hF0, 10);

        q = '{8'h96};
        apply_stimulus(1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usb_uart_tx.md
# usb_uart_tx

Serial transmitter stage directly downstream of the USB OUT endpoint receive buffer. Pulls bytes from the endpoint's UART pipeline interface using its valid/get handshake and serializes each one onto an asynchronous TX line. The frame is LSB-first 8N1, with an optional parity bit and a configurable stop-bit count. Bit timing comes from an integer clock divider; no other clock domain is involved.

## Interface

Parameters:
- CLKS_PER_BIT, 417, `clk` cycles per serial bit; legal range ≥ 2; counter width is `$clog2(CLKS_PER_BIT)`.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic rises on posedge.
- reset  input  1  asynchronous, active-low reset.
- uart_out_data  input  8  byte presented by the upstream buffer; valid whenever `uart_out_valid` is high.
- uart_out_valid  input  1  upstream has a byte available.
- uart_out_get  output  1  one-cycle pulse; consumes the current byte on this clock edge.
- uart_tx  output  1  serial line; idle level is high.
- tx_busy  output  1  high while a frame is in progress (any state other than IDLE).

## Operation

- Reset (`reset` low, asynchronous) forces the following, independent of `clk`:
  - state = IDLE
  - `uart_tx` = 1
  - `uart_out_get` = 0
  - `tx_busy` = 0
  - baud counter = 0, bit index = 0, shift register = 0
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
- IDLE
  - `uart_out_get` = `uart_out_valid` (combinational).
  - On a cycle with get high: latch `uart_out_data` into the shift register, load the baud counter with CLKS_PER_BIT-1, and go to START.
- START: drive `uart_tx` = 0 for CLKS_PER_BIT cycles.
- DATA
  - Drive shift[0] for each bit; bit 0 goes first.
  - At each bit end, shift right by 1 and increment the 3-bit index.
  - After index 7 completes, go to PARITY if compiled in, otherwise STOP.
- PARITY: drive the XOR of the 8 latched data bits (even parity).
- STOP: drive `uart_tx` = 1 for STOP_BITS × CLKS_PER_BIT cycles.
- Last cycle of STOP:
  - If `uart_out_valid` is high, assert `uart_out_get`, latch the byte, and go straight to START. This gives zero idle gap between frames.
  - Otherwise go to IDLE.
- Baud counter
  - Counts down and reloads to CLKS_PER_BIT-1 at each bit boundary.
  - A bit boundary is a counter value of 0.
  - The counter never underflows.
- `uart_out_get` is asserted only in IDLE or in the last cycle of STOP. It is never asserted while `uart_out_valid` is low.
- `uart_out_data` is sampled only on a get edge. Upstream changes at any other time have no effect.
- `uart_tx` is driven from a register, so there are no combinational glitches on the line.

## Timing

- `uart_out_valid` rises in cycle N while in IDLE:
  - `uart_out_get` is high in cycle N.
  - `uart_tx` falls at the edge ending N, i.e. it is low from cycle N+1.
- Frame length is (1 + 8 + P + STOP_BITS) × CLKS_PER_BIT cycles, with P = 1 if parity is enabled.
- `tx_busy` rises with the start bit. It falls on the edge that returns to IDLE, which is the same cycle `uart_tx` is already high for the final stop cycle.
- Back-to-back frames: the next start bit begins exactly one bit period after the final stop bit's start. There is no extra idle cycle.
- `uart_out_valid` falling mid-frame has no effect on the frame in progress.
- Reset asserted mid-frame: `uart_tx` goes high immediately and the partial frame is abandoned. Upstream is not re-fetched for that byte.
- Reset release: the first get can occur on the first posedge after deassertion.

## Configuration

- `USB_UART_TX_PARITY_EN`
  - Defined: the PARITY state exists. One even-parity bit is sent between data bit 7 and the first stop bit. Frame length is 11 bits (STOP_BITS=1).
  - Undefined: the PARITY state, its logic and the parity register are compiled out. DATA goes directly to STOP. Frame length is 10 bits (STOP_BITS=1).

## Test plan

- Reset: hold `reset` low with `uart_out_valid`=1, `uart_out_data`=0xFF.
  - Expect `uart_tx`=1, `uart_out_get`=0 and `tx_busy`=0 throughout.
- Single byte, CLKS_PER_BIT=4, no parity, byte 0x55 presented for one get.
  - Expect exactly one get pulse.
  - `uart_tx` = 0, 1,0,1,0,1,0,1,0, 1, each held 4 cycles; total 40 cycles.
  - Then `tx_busy`=0.
- Back-to-back: 0xA5 then 0x3C with valid held high.
  - Expect a second get in the last stop cycle of frame 1.
  - Frame 2's start bit follows immediately (80 contiguous cycles); serial bits are LSB-first 1,0,1,0,0,1,0,1 and then 0,0,1,1,1,1,0,0.
- STOP_BITS=2, byte 0x00: stop high for 8 cycles, frame 44 cycles.
- Reset mid-frame: assert reset during data bit 3 of 0x0F.
  - Expect `uart_tx`=1 asynchronously, with no further get until reset is released.
- Parity build with `USB_UART_TX_PARITY_EN`, byte 0x07: parity bit = 1; 44-cycle frame at CLKS_PER_BIT=4.
